// File: rtl/emin_pkg.sv
// Shared definitions for the Emin row scheduler.
//   state_e : scheduler FSM states
//   tri_aw  : address width of a triangular buffer holding rows 0..n-1,
//             where row i holds i+1 words
package emin_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ROW_DONE,
    DONE
  } state_e;

  function automatic int tri_aw(input int n);
    return $clog2(n * (n + 1) / 2);
  endfunction

endpackage

// File: rtl/emin_rowmin.sv
// Running signed minimum / argmin of the results of one row.
//   clk_in, rst_in  : clock, synchronous active-high reset
//   clr_in          : clear to zero (start of a sweep)
//   load_in         : first result of a row, unconditional load
//   upd_in          : later result, replaces only if strictly smaller
//   data_in, j_in   : result word and its column index
//   min_out, argmin_out : current minimum and its column
module emin_rowmin #(
  parameter int BIT_WIDTH = 32,
  parameter int IW        = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 clr_in,
  input  logic                 load_in,
  input  logic                 upd_in,
  input  logic [BIT_WIDTH-1:0] data_in,
  input  logic [IW-1:0]        j_in,
  output logic [BIT_WIDTH-1:0] min_out,
  output logic [IW-1:0]        argmin_out
);

  logic [BIT_WIDTH-1:0] min_q, min_d;
  logic [IW-1:0]        arg_q, arg_d;

  always_comb begin
    min_d = min_q;
    arg_d = arg_q;
    if (clr_in) begin
      min_d = '0;
      arg_d = '0;
    end else if (load_in || (upd_in && ($signed(data_in) < $signed(min_q)))) begin
      // strict compare: ties keep the earlier (lower) column
      min_d = data_in;
      arg_d = j_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      min_q <= '0;
      arg_q <= '0;
    end else begin
      min_q <= min_d;
      arg_q <= arg_d;
    end
  end

  assign min_out    = min_q;
  assign argmin_out = arg_q;

endmodule

// File: rtl/emin_sched.sv
// Emin row scheduler: launches rows 0..n-1 into the Emin datapath, writes
// each returned word to a triangular E buffer (row i at base i*(i+1)/2),
// and reports the per-row signed minimum / argmin.
//   clk_in, rst_in        : clock, synchronous active-high reset
//   start_in, n_in        : sweep start pulse and row count (0..I)
//   emin_i_out/valid_out  : row launch to the datapath
//   emin_valid_in/j_in/data_in : results from the datapath
//   wr_en/addr/data_out   : E buffer write port (one cycle after a result)
//   row_valid/i/min/argmin_out : per-row minimum report
//   busy_out, done_out, err_out : status
module emin_sched
  import emin_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160,
  parameter int TIMEOUT   = 1023,
  localparam int IW       = $clog2(I),
  localparam int AW       = tri_aw(I)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [IW:0]          n_in,
  output logic [IW-1:0]        emin_i_out,
  output logic                 emin_valid_out,
  input  logic                 emin_valid_in,
  input  logic [IW-1:0]        emin_j_in,
  input  logic [BIT_WIDTH-1:0] emin_data_in,
  output logic                 wr_en_out,
  output logic [AW-1:0]        wr_addr_out,
  output logic [BIT_WIDTH-1:0] wr_data_out,
  output logic                 row_valid_out,
  output logic [IW-1:0]        row_i_out,
  output logic [BIT_WIDTH-1:0] row_min_out,
  output logic [IW-1:0]        row_argmin_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 err_out
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [IW:0]          n_q, n_d;
  logic [IW-1:0]        i_q, i_d, exp_j_q, exp_j_d;
  logic [AW-1:0]        base_q, base_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic                 err_q, err_d;
  logic                 ev_q, ev_d, wr_en_q, wr_en_d, rv_q, rv_d, done_q, done_d;
  logic [IW-1:0]        ei_q, ei_d, ri_q, ri_d, ra_q, ra_d;
  logic [AW-1:0]        wa_q, wa_d;
  logic [BIT_WIDTH-1:0] wdat_q, wdat_d, rm_q, rm_d;
  logic [BIT_WIDTH-1:0] min_w;
  logic [IW-1:0]        arg_w;
  logic                 start_acc, res_ok, row_end, timeout, last_row;

  assign start_acc = (state_q == IDLE) && start_in;
  assign res_ok    = (state_q == WAIT) && emin_valid_in;
  assign row_end   = res_ok && (exp_j_q == i_q);
  assign timeout   = (state_q == WAIT) && !emin_valid_in &&
                     (wd_q + 1'b1 == WDW'(TIMEOUT));
  assign last_row  = ({1'b0, i_q} == n_q - 1'b1);

  emin_rowmin #(.BIT_WIDTH(BIT_WIDTH), .IW(IW)) u_rowmin (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clr_in     (start_acc),
    .load_in    (res_ok && (exp_j_q == '0)),
    .upd_in     (res_ok && (exp_j_q != '0)),
    .data_in    (emin_data_in),
    .j_in       (exp_j_q),
    .min_out    (min_w),
    .argmin_out (arg_w)
  );

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start_in) state_d = (n_in == '0) ? DONE : ISSUE;
      ISSUE:    state_d = WAIT;
      WAIT:     if (row_end) state_d = ROW_DONE;
                else if (timeout) state_d = DONE;
      ROW_DONE: state_d = last_row ? DONE : ISSUE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // counters and sticky error
  always_comb begin
    n_d     = n_q;
    i_d     = i_q;
    base_d  = base_q;
    exp_j_d = exp_j_q;
    wd_d    = wd_q;
    err_d   = err_q;
    if (start_acc) begin
      n_d    = n_in;
      i_d    = '0;
      base_d = '0;
      err_d  = 1'b0;
    end
    if (state_q == ISSUE) begin
      exp_j_d = '0;
      wd_d    = '0;
    end
    if (state_q == WAIT) begin
      if (emin_valid_in) begin
        exp_j_d = exp_j_q + 1'b1;
        wd_d    = '0;
        if (emin_j_in != exp_j_q) err_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
        if (timeout) err_d = 1'b1;
      end
    end
    if (state_q == ROW_DONE) begin
      base_d = base_q + AW'(i_q) + 1'b1;
      i_d    = i_q + 1'b1;
    end
    // stray results during a sweep flag an error; in IDLE they are leftovers
    // of an abandoned sweep and are dropped silently
    if (emin_valid_in && (state_q != WAIT) && (state_q != IDLE)) err_d = 1'b1;
  end

  // registered outputs
  always_comb begin
    ev_d    = (state_d == ISSUE);
    ei_d    = (state_d == ISSUE) ? i_d : ei_q;
    wr_en_d = res_ok;
    wa_d    = res_ok ? base_q + AW'(exp_j_q) : wa_q;
    wdat_d  = res_ok ? emin_data_in : wdat_q;
    rv_d    = (state_q == ROW_DONE);
    ri_d    = (state_q == ROW_DONE) ? i_q : ri_q;
    rm_d    = (state_q == ROW_DONE) ? min_w : rm_q;
    ra_d    = (state_q == ROW_DONE) ? arg_w : ra_q;
    done_d  = (state_q == DONE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
      base_q  <= '0;
      exp_j_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      ev_q    <= 1'b0;
      ei_q    <= '0;
      wr_en_q <= 1'b0;
      wa_q    <= '0;
      wdat_q  <= '0;
      rv_q    <= 1'b0;
      ri_q    <= '0;
      rm_q    <= '0;
      ra_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      base_q  <= base_d;
      exp_j_q <= exp_j_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      ev_q    <= ev_d;
      ei_q    <= ei_d;
      wr_en_q <= wr_en_d;
      wa_q    <= wa_d;
      wdat_q  <= wdat_d;
      rv_q    <= rv_d;
      ri_q    <= ri_d;
      rm_q    <= rm_d;
      ra_q    <= ra_d;
      done_q  <= done_d;
    end
  end

  assign emin_valid_out = ev_q;
  assign emin_i_out     = ei_q;
  assign wr_en_out      = wr_en_q;
  assign wr_addr_out    = wa_q;
  assign wr_data_out    = wdat_q;
  assign row_valid_out  = rv_q;
  assign row_i_out      = ri_q;
  assign row_min_out    = rm_q;
  assign row_argmin_out = ra_q;
  assign busy_out       = (state_q != IDLE);
  assign done_out       = done_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_emin_sched.sv
module tb_emin_sched;
  localparam int BW = 16, NI = 8, TO = 20;
  localparam int IW = $clog2(NI), AW = $clog2(NI * (NI + 1) / 2), NW = IW + 1;

  logic clk_in = 1'b0, rst_in, start_in, emin_valid_in;
  logic [NW-1:0] n_in;
  logic [IW-1:0] emin_j_in, emin_i_out, row_i_out, row_argmin_out;
  logic [BW-1:0] emin_data_in, wr_data_out, row_min_out;
  logic [AW-1:0] wr_addr_out;
  logic emin_valid_out, wr_en_out, row_valid_out, busy_out, done_out, err_out;

  emin_sched #(.BIT_WIDTH(BW), .I(NI), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .n_in(n_in),
    .emin_i_out(emin_i_out), .emin_valid_out(emin_valid_out),
    .emin_valid_in(emin_valid_in), .emin_j_in(emin_j_in), .emin_data_in(emin_data_in),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .row_valid_out(row_valid_out), .row_i_out(row_i_out), .row_min_out(row_min_out),
    .row_argmin_out(row_argmin_out), .busy_out(busy_out), .done_out(done_out),
    .err_out(err_out));

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  logic [BW-1:0] dat [NI][NI];

  // observation log, only appended here
  int wa_q[$], ri_q[$], ra_q[$];
  logic [BW-1:0] wv_q[$], rm_q[$];
  int ev_cnt = 0, done_cnt = 0, done_cyc = 0;
  always @(negedge clk_in) begin
    if (wr_en_out) begin wa_q.push_back(int'(wr_addr_out)); wv_q.push_back(wr_data_out); end
    if (row_valid_out) begin
      ri_q.push_back(int'(row_i_out)); rm_q.push_back(row_min_out); ra_q.push_back(int'(row_argmin_out));
    end
    if (emin_valid_out) ev_cnt <= ev_cnt + 1;
    if (done_out) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
  end

  // Datapath stand-in: answers each launched row r with j=0..r.
  // cut_row/cut_cnt: stop after cut_cnt results of that row; bad_row: send j=1 for j=0.
  task automatic sweep(input int n, input int cut_row, input int cut_cnt, input int bad_row,
                       output int t_last);
    t_last = 0;
    @(posedge clk_in); #1 start_in = 1'b1; n_in = NW'(n);
    @(posedge clk_in); #1 start_in = 1'b0;
    for (int r = 0; r < n; r++) begin
      int k = 0;
      while (emin_valid_out !== 1'b1 && k < 40) begin @(posedge clk_in); #1; k++; end
      n_cmp++;
      if (k >= 40) begin
        n_bad++; $display("FAIL launch_row%0d: emin_valid_out=%b after %0d cycles, required 1", r, emin_valid_out, k);
        return;
      end
      n_cmp++;
      if (emin_i_out !== IW'(r)) begin
        n_bad++; $display("FAIL launch_idx: emin_i_out=%0d, required %0d", emin_i_out, r);
      end
      for (int j = 0; j <= r; j++) begin
        if (r == cut_row && j == cut_cnt) begin
          if (j > 0) begin @(posedge clk_in); #1 emin_valid_in = 1'b0; end
          return;
        end
        @(posedge clk_in); #1 emin_valid_in = 1'b1;
        emin_j_in = (r == bad_row && j == 0) ? IW'(1) : IW'(j);
        emin_data_in = dat[r][j];
        t_last = cyc;
      end
      @(posedge clk_in); #1 emin_valid_in = 1'b0;
    end
  endtask

  task automatic wait_done(input int dc0, output bit seen);
    int k = 0;
    while (done_cnt == dc0 && k < 200) begin @(negedge clk_in); #1; k++; end
    seen = (done_cnt != dc0);
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy_out); end
    n_cmp++; if (done_out !== 1'b0 || err_out !== 1'b0) begin n_bad++; $display("FAIL rst_status: done=%b err=%b, required 0 0", done_out, err_out); end
    n_cmp++; if ({emin_valid_out, wr_en_out, row_valid_out} !== 3'b000) begin n_bad++; $display("FAIL rst_strobes: got %b, required 000", {emin_valid_out, wr_en_out, row_valid_out}); end
    n_cmp++; if (emin_i_out !== '0 || wr_addr_out !== '0 || wr_data_out !== '0 || row_min_out !== '0) begin
      n_bad++; $display("FAIL rst_data: i=%0d addr=%0d data=%0d min=%0d, required 0", emin_i_out, wr_addr_out, wr_data_out, row_min_out);
    end
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b, required 0", busy_out); end
  endtask

  task automatic test_sweeps();
    for (int s = 0; s < 5; s++) begin
      int n, wa0, r0, ev0, dc0, t_last, k, am;
      bit seen;
      logic [BW-1:0] m;
      if (s == 0) begin
        n = 3;
        dat[0][0] = BW'(5);
        dat[1][0] = BW'(-2); dat[1][1] = BW'(7);
        dat[2][0] = BW'(4);  dat[2][1] = BW'(-9); dat[2][2] = BW'(-9);
      end else begin
        n = $urandom_range(1, NI);
        for (int i = 0; i < NI; i++)
          for (int j = 0; j < NI; j++) dat[i][j] = BW'(int'($urandom_range(0, 15)) - 8);
      end
      wa0 = wa_q.size(); r0 = ri_q.size(); ev0 = ev_cnt; dc0 = done_cnt;
      sweep(n, -1, 0, -1, t_last);
      wait_done(dc0, seen);
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL done_missing: sweep %0d n=%0d, required done_out", s, n); end
      else if (done_cyc != t_last + 3) begin
        n_bad++; $display("FAIL done_latency: done in cycle %0d, required %0d", done_cyc, t_last + 3);
      end
      n_cmp++;
      if (wa_q.size() - wa0 != n * (n + 1) / 2) begin
        n_bad++; $display("FAIL write_count: got %0d, required %0d", wa_q.size() - wa0, n * (n + 1) / 2);
      end
      k = wa0;
      for (int i = 0; i < n; i++)
        for (int j = 0; j <= i; j++) begin
          if (k < wa_q.size()) begin
            n_cmp++;
            if (wa_q[k] != i * (i + 1) / 2 + j || wv_q[k] !== dat[i][j]) begin
              n_bad++; $display("FAIL write_%0d_%0d: addr=%0d data=%0d, required addr=%0d data=%0d",
                                i, j, wa_q[k], $signed(wv_q[k]), i * (i + 1) / 2 + j, $signed(dat[i][j]));
            end
          end
          k++;
        end
      n_cmp++;
      if (ri_q.size() - r0 != n) begin n_bad++; $display("FAIL row_count: got %0d, required %0d", ri_q.size() - r0, n); end
      for (int i = 0; i < n; i++) begin
        m = dat[i][0]; am = 0;
        for (int j = 1; j <= i; j++)
          if ($signed(dat[i][j]) < $signed(m)) begin m = dat[i][j]; am = j; end
        if (r0 + i < ri_q.size()) begin
          n_cmp++;
          if (ri_q[r0 + i] != i || rm_q[r0 + i] !== m || ra_q[r0 + i] != am) begin
            n_bad++; $display("FAIL row_min_%0d: i=%0d min=%0d arg=%0d, required i=%0d min=%0d arg=%0d",
                              i, ri_q[r0 + i], $signed(rm_q[r0 + i]), ra_q[r0 + i], i, $signed(m), am);
          end
        end
      end
      n_cmp++; if (err_out !== 1'b0) begin n_bad++; $display("FAIL sweep_err: got %b, required 0", err_out); end
      n_cmp++; if (ev_cnt - ev0 != n) begin n_bad++; $display("FAIL launch_count: got %0d, required %0d", ev_cnt - ev0, n); end
    end
  endtask

  task automatic test_zero();
    int wa0, ev0, dc0, c0;
    wa0 = wa_q.size(); ev0 = ev_cnt; dc0 = done_cnt;
    @(posedge clk_in); #1 start_in = 1'b1; n_in = '0; c0 = cyc;
    @(posedge clk_in); #1 start_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    n_cmp++; if (done_cnt - dc0 != 1) begin n_bad++; $display("FAIL zero_done_count: got %0d, required 1", done_cnt - dc0); end
    n_cmp++; if (done_cyc != c0 + 2) begin n_bad++; $display("FAIL zero_done_cycle: got %0d, required %0d", done_cyc, c0 + 2); end
    n_cmp++; if (wa_q.size() != wa0 || ev_cnt != ev0) begin
      n_bad++; $display("FAIL zero_activity: writes=%0d launches=%0d, required 0 0", wa_q.size() - wa0, ev_cnt - ev0);
    end
    n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b, required 0", busy_out); end
  endtask

  task automatic test_timeout();
    int wa0, r0, dc0, t_last;
    bit seen;
    wa0 = wa_q.size(); r0 = ri_q.size(); dc0 = done_cnt;
    sweep(3, 1, 0, -1, t_last);
    wait_done(dc0, seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL to_done: no done_out, required one"); end
    n_cmp++; if (err_out !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b, required 1", err_out); end
    n_cmp++; if (ri_q.size() - r0 != 1) begin n_bad++; $display("FAIL to_rows: got %0d rows, required 1", ri_q.size() - r0); end
    n_cmp++; if (wa_q.size() - wa0 != 1) begin n_bad++; $display("FAIL to_writes: got %0d, required 1", wa_q.size() - wa0); end
  endtask

  task automatic test_bad_j();
    int wa0, dc0, t_last;
    bit seen;
    wa0 = wa_q.size(); dc0 = done_cnt;
    dat[0][0] = BW'(11); dat[1][0] = BW'(3); dat[1][1] = BW'(-1);
    sweep(2, -1, 0, 0, t_last);
    wait_done(dc0, seen);
    n_cmp++; if (err_out !== 1'b1) begin n_bad++; $display("FAIL badj_err: got %b, required 1", err_out); end
    n_cmp++; if (wa_q.size() - wa0 != 3) begin n_bad++; $display("FAIL badj_writes: got %0d, required 3", wa_q.size() - wa0); end
    else begin
      n_cmp++;
      if (wa_q[wa0] != 0 || wv_q[wa0] !== BW'(11)) begin
        n_bad++; $display("FAIL badj_addr: addr=%0d data=%0d, required addr=0 data=11", wa_q[wa0], wv_q[wa0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int wmark, wa0, dc0, t_last;
    bit seen;
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < NI; j++) dat[i][j] = BW'(int'($urandom_range(0, 15)) - 8);
    sweep(3, 2, 1, -1, t_last);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    wmark = wa_q.size();
    @(posedge clk_in); #1 rst_in = 1'b0;
    emin_valid_in = 1'b1; emin_j_in = IW'(1); emin_data_in = BW'(3);
    @(posedge clk_in); #1 emin_j_in = IW'(2);
    @(posedge clk_in); #1 emin_valid_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    n_cmp++; if (wa_q.size() != wmark) begin n_bad++; $display("FAIL rmid_writes: got %0d extra, required 0", wa_q.size() - wmark); end
    n_cmp++; if (err_out !== 1'b0 || busy_out !== 1'b0) begin
      n_bad++; $display("FAIL rmid_status: err=%b busy=%b, required 0 0", err_out, busy_out);
    end
    wa0 = wa_q.size(); dc0 = done_cnt;
    sweep(2, -1, 0, -1, t_last);
    wait_done(dc0, seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rmid_done: no done_out, required one"); end
    n_cmp++; if (wa_q.size() - wa0 != 3) begin n_bad++; $display("FAIL rmid_count: got %0d, required 3", wa_q.size() - wa0); end
    else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (wa_q[wa0 + k] != k) begin n_bad++; $display("FAIL rmid_addr%0d: got %0d, required %0d", k, wa_q[wa0 + k], k); end
      end
    end
    n_cmp++; if (err_out !== 1'b0) begin n_bad++; $display("FAIL rmid_err: got %b, required 0", err_out); end
  endtask

  initial begin
    rst_in = 1'b1; start_in = 1'b0; n_in = '0;
    emin_valid_in = 1'b0; emin_j_in = '0; emin_data_in = '0;
    test_reset();
    test_sweeps();
    test_zero();
    test_timeout();
    test_bad_j();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
